// File: rtl/core_pkg.sv
// Shared RV32I control definitions: base opcodes, sequencer state encoding and
// the select/cause codes driven towards the datapath.
package core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_I_LOAD = 7'b0000011;
  localparam logic [6:0] OP_I_JALR = 7'b1100111;
  localparam logic [6:0] OP_S      = 7'b0100011;
  localparam logic [6:0] OP_B      = 7'b1100011;
  localparam logic [6:0] OP_U      = 7'b0110111;
  localparam logic [6:0] OP_U_PC   = 7'b0010111;
  localparam logic [6:0] OP_J      = 7'b1101111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_CSR    = 7'b1110011;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT, ST_TRAP
  } state_t;

  localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MDR = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
  localparam logic [1:0] TRAP_BUS     = 2'd2;
  localparam logic [1:0] TRAP_ECALL   = 2'd3;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_I_LOAD, OP_I_JALR, OP_S, OP_B,
      OP_U, OP_U_PC, OP_J, OP_FENCE, OP_CSR: is_legal_opcode = 1'b1;
      default:                               is_legal_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Bus-timeout watchdog: counts cycles a memory request stays outstanding and
// flags expiry on the cycle the limit is reached without an acknowledge.
module seq_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_active,
  output logic o_expired
);

  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Holding the count at zero while no request is up gives the clear on entry
  // to FETCH/MEM, since those are the only states that raise a request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear || !i_active || (MEM_TIMEOUT == 0)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expired = (MEM_TIMEOUT != 0) && i_active && !i_clear && (r_count == LIMIT);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb over one shared
// memory port, with retire counting and sticky halt/trap status.
module core_sequencer
  import core_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [6:0]           opcode,
  input  logic                 branch_taken,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_addr_sel,
  output logic                 ir_load,
  output logic                 mdr_load,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic                 retire,
  output logic [INSTRET_W-1:0] instret,
  output logic                 halted,
  output logic [1:0]           trap_cause,
  output state_t               dbg_state
);

  // Memory handshake: mem_req rises on entry to FETCH/MEM and stays high, with
  // mem_we/mem_addr_sel stable, until the one-cycle mem_ack pulse completes it.
  state_t                 r_state;
  state_t                 w_next;
  logic [1:0]             r_trap_cause;
  logic [1:0]             w_next_cause;
  logic [INSTRET_W-1:0]   r_instret;
  logic                   w_wd_expired;

  seq_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (mem_ack),
    .i_active  (mem_req),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_trap_cause <= TRAP_NONE;
      r_instret    <= '0;
    end else begin
      r_state      <= w_next;
      r_trap_cause <= w_next_cause;
      if (retire) r_instret <= r_instret + INSTRET_W'(1);
    end
  end

  always_comb begin
    w_next       = r_state;
    w_next_cause = r_trap_cause;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    mdr_load     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_PLUS4;
    reg_write    = 1'b0;
    wb_sel       = WB_SEL_ALU;
    retire       = 1'b0;
    halted       = 1'b0;
    case (r_state)
      ST_IDLE: if (run) w_next = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load = 1'b1;
          w_next  = ST_DECODE;
        end else if (w_wd_expired) begin
          w_next       = ST_TRAP;
          w_next_cause = TRAP_BUS;
        end
      end
      ST_DECODE: begin
        if (is_legal_opcode(opcode)) begin
          w_next = ST_EXEC;
        end else begin
          w_next       = ST_TRAP;
          w_next_cause = TRAP_ILLEGAL;
        end
      end
      ST_EXEC: begin
        case (opcode)
          OP_B: begin
            pc_write = 1'b1;
            pc_src   = branch_taken ? PC_SRC_BRANCH : PC_SRC_PLUS4;
            retire   = 1'b1;
          end
          OP_J, OP_I_JALR: begin
            reg_write = 1'b1;
            wb_sel    = WB_SEL_PC4;
            pc_write  = 1'b1;
            pc_src    = PC_SRC_JUMP;
            retire    = 1'b1;
          end
          OP_FENCE: begin
            pc_write = 1'b1;
            retire   = 1'b1;
          end
          OP_I_LOAD, OP_S:         w_next = ST_MEM;
          OP_R, OP_I, OP_U, OP_U_PC: w_next = ST_WB;
          OP_CSR: begin
            w_next       = ST_HALT;
            w_next_cause = TRAP_ECALL;
          end
          default: begin
            w_next       = ST_TRAP;
            w_next_cause = TRAP_ILLEGAL;
          end
        endcase
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode == OP_S);
        if (mem_ack) begin
          if (opcode == OP_S) begin
            pc_write = 1'b1;
            retire   = 1'b1;
          end else begin
            mdr_load = 1'b1;
            w_next   = ST_WB;
          end
        end else if (w_wd_expired) begin
          w_next       = ST_TRAP;
          w_next_cause = TRAP_BUS;
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        wb_sel    = (opcode == OP_I_LOAD) ? WB_SEL_MDR : WB_SEL_ALU;
        pc_write  = 1'b1;
        retire    = 1'b1;
      end
      ST_HALT, ST_TRAP: halted = 1'b1;
      default: w_next = ST_IDLE;
    endcase
    if (retire) w_next = run ? ST_FETCH : ST_IDLE;
  end

  assign instret    = r_instret;
  assign trap_cause = r_trap_cause;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: per-cycle expected control words are queued as each
// instruction is driven and compared against the DUT outputs every cycle.
module tb_core_sequencer;
  import core_pkg::*;

  localparam int TO = 4;
  localparam int IW = 32;
  localparam int OW = 15 + IW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic [6:0]    opcode = 7'd0;
  logic          branch_taken = 1'b0;
  logic          mem_ack = 1'b0;
  logic          mem_req, mem_we, mem_addr_sel, ir_load, mdr_load, pc_write;
  logic [1:0]    pc_src, wb_sel, trap_cause;
  logic          reg_write, retire, halted;
  logic [IW-1:0] instret;
  state_t        dbg_state;

  core_sequencer #(.MEM_TIMEOUT(TO), .INSTRET_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ack(mem_ack), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_load(ir_load),
    .mdr_load(mdr_load), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .wb_sel(wb_sel), .retire(retire),
    .instret(instret), .halted(halted), .trap_cause(trap_cause),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  // scoreboard
  logic [OW-1:0] exp_q[$];
  logic [IW-1:0] exp_instret = '0;
  int            n_checks = 0;
  int            n_errors = 0;
  logic [OW-1:0] w_obs;

  assign w_obs = {mem_req, mem_we, mem_addr_sel, ir_load, mdr_load, pc_write, pc_src,
                  reg_write, wb_sel, retire, halted, trap_cause, instret};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] cv(input logic req, input logic we, input logic asel,
                                     input logic irl, input logic mdrl, input logic pcw,
                                     input logic [1:0] pcs, input logic rw,
                                     input logic [1:0] wbs, input logic ret,
                                     input logic hlt, input logic [1:0] tc);
    return {req, we, asel, irl, mdrl, pcw, pcs, rw, wbs, ret, hlt, tc};
  endfunction

  function automatic logic legal_op(input logic [6:0] op);
    return op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                      7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111,
                      7'b1110011};
  endfunction

  // Inputs for the cycle are already driven; queue the expectation, sample
  // mid-cycle, then move to the next negedge.
  task automatic tick(input string tag, input logic [14:0] c);
    exp_q.push_back({c, exp_instret});
    #1;
    check_eq(tag, 64'(w_obs), 64'(exp_q.pop_front()));
    if (c[3]) exp_instret++;
    @(negedge clk);
  endtask

  // driver tasks
  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0; branch_taken = 1'b0; opcode = 7'd0;
    @(negedge clk);
    exp_instret = '0;
    tick("reset", '0);
    rst_n = 1'b1;
  endtask

  task automatic term(input logic [1:0] tc);
    run = 1'b1;
    tick("term0", cv(0,0,0,0,0,0,2'd0,0,2'd0,0,1,tc));
    mem_ack = 1'b1;
    tick("term_late_ack", cv(0,0,0,0,0,0,2'd0,0,2'd0,0,1,tc));
    mem_ack = 1'b0;
    tick("term2", cv(0,0,0,0,0,0,2'd0,0,2'd0,0,1,tc));
  endtask

  // Starts in FETCH; returns at the cycle after retire (or after the terminal checks).
  task automatic do_instr(input logic [31:0] instr, input int fwait, input int mwait,
                          input logic taken, input logic run_v);
    logic [6:0] op;
    logic       st;
    op = instr[6:0];
    st = (op == 7'b0100011);
    run = run_v; branch_taken = taken; mem_ack = 1'b0;
    for (int i = 0; i < fwait && i < TO; i++)
      tick("fetch_wait", cv(1,0,0,0,0,0,2'd0,0,2'd0,0,0,2'd0));
    if (fwait >= TO) begin
      term(2'd2);
      return;
    end
    mem_ack = 1'b1; opcode = op;
    tick("fetch_ack", cv(1,0,0,1,0,0,2'd0,0,2'd0,0,0,2'd0));
    mem_ack = 1'b0;
    tick("decode", '0);
    if (!legal_op(op)) begin
      term(2'd1);
      return;
    end
    case (op)
      7'b1100011: tick("exec_branch", cv(0,0,0,0,0,1,taken ? 2'd1 : 2'd0,0,2'd0,1,0,2'd0));
      7'b1101111, 7'b1100111: tick("exec_jump", cv(0,0,0,0,0,1,2'd2,1,2'd2,1,0,2'd0));
      7'b0001111: tick("exec_fence", cv(0,0,0,0,0,1,2'd0,0,2'd0,1,0,2'd0));
      7'b1110011: begin
        tick("exec_system", '0);
        term(2'd3);
      end
      default: begin
        tick("exec", '0);
        if (op == 7'b0000011 || st) begin
          for (int i = 0; i < mwait && i < TO; i++)
            tick("mem_wait", cv(1,st,1,0,0,0,2'd0,0,2'd0,0,0,2'd0));
          if (mwait >= TO) begin
            term(2'd2);
            return;
          end
          mem_ack = 1'b1;
          if (st) begin
            tick("mem_store", cv(1,1,1,0,0,1,2'd0,0,2'd0,1,0,2'd0));
            mem_ack = 1'b0;
            return;
          end
          tick("mem_load", cv(1,0,1,0,1,0,2'd0,0,2'd0,0,0,2'd0));
          mem_ack = 1'b0;
        end
        tick("wb", cv(0,0,0,0,0,1,2'd0,1,(op == 7'b0000011) ? 2'd1 : 2'd0,1,0,2'd0));
      end
    endcase
  endtask

  logic [31:0] pool [10] = '{32'h00500093, 32'h00002103, 32'h00202023, 32'h00000063,
                             32'h008000EF, 32'h000080E7, 32'h123450B7, 32'h00001097,
                             32'h002081B3, 32'h0000000F};

  initial begin
    @(negedge clk);
    do_reset();
    run = 1'b1;
    tick("idle_start", '0);
    #1;
    check_eq("fetch_req_before_rst", 64'(mem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("req_in_reset", 64'(mem_req), 64'd0);
    check_eq("instret_in_reset", 64'(instret), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick("idle_after_rst", '0);

    do_instr(32'h00500093, 0, 0, 1'b0, 1'b1);  // ADDI
    do_instr(32'h00002103, 0, 3, 1'b0, 1'b1);  // LW, ack on last allowed cycle
    do_instr(32'h00000063, 0, 0, 1'b1, 1'b1);  // BEQ taken
    do_instr(32'h00000063, 1, 0, 1'b0, 1'b1);  // BEQ not taken
    do_instr(32'h00202023, 0, 2, 1'b0, 1'b0);  // SW with run dropped
    for (int i = 0; i < 3; i++) tick("idle_parked", '0);
    run = 1'b1;
    tick("idle_resume", '0);
    do_instr(32'h008000EF, 0, 0, 1'b0, 1'b1);  // JAL
    do_instr(32'h0000000F, 0, 0, 1'b0, 1'b1);  // FENCE
    do_instr(32'h123450B7, 2, 0, 1'b0, 1'b1);  // LUI
    do_instr(32'h000080E7, 0, 0, 1'b0, 1'b1);  // JALR

    for (int n = 0; n < 24; n++)
      do_instr(pool[$urandom_range(0, 9)], int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);

    do_instr(32'h0000007F, 0, 0, 1'b0, 1'b1);  // illegal opcode
    do_reset();
    run = 1'b1;
    tick("idle_ecall", '0);
    do_instr(32'h00000073, 0, 0, 1'b0, 1'b1);  // ECALL
    do_reset();
    run = 1'b1;
    tick("idle_fetch_to", '0);
    do_instr(32'h00500093, TO, 0, 1'b0, 1'b1); // fetch timeout
    do_reset();
    run = 1'b1;
    tick("idle_ack_at_limit", '0);
    do_instr(32'h00500093, TO - 1, 0, 1'b0, 1'b1);
    do_instr(32'h00002103, 0, TO, 1'b0, 1'b1); // load timeout
    do_reset();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
